// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder: FSM state encoding and the
// default operand width.
// ---------------------------------------------------------------------------
package serial_adder_pkg;

    // FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sa_state_t;

    // Default operand / sum width
    localparam int SA_WIDTH_DEF = 8;

endpackage : serial_adder_pkg

// File: rtl/dataflow_fulladder.sv
// ---------------------------------------------------------------------------
// dataflow_fulladder
// Combinational one-bit full adder.
//   first, second : addend bits
//   cin           : carry in
//   sum           : first ^ second ^ cin
//   cout          : carry out
// ---------------------------------------------------------------------------
module dataflow_fulladder (
    input  logic first,
    input  logic second,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic half_sum;

    assign half_sum = first ^ second;
    assign sum      = half_sum ^ cin;
    assign cout     = (first & second) | (cin & half_sum);

endmodule : dataflow_fulladder

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
// Bit-serial ripple adder: {cout,sum} = a + b + cin, one bit per clock,
// LSB first, through a single full-adder cell and a registered carry.
//
// Parameters:
//   WIDTH  operand/sum width (>= 2), default SA_WIDTH_DEF
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   start  request, sampled only in IDLE
//   a, b   operands, captured on the accepting edge
//   cin    carry in, captured on the accepting edge
//   busy   high in RUN and DONE
//   done   one-cycle pulse, sum/cout (and ovf) valid
//   sum    result, held until the next accepted start
//   cout   carry out of the MSB, held with sum
//   ovf    signed overflow (only when SERIAL_ADDER_OVF_EN is defined)
//
// Optional feature macro: SERIAL_ADDER_OVF_EN
// ---------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    sa_state_t        state_reg, state_next;
    logic [WIDTH-1:0] sa_reg;
    logic [WIDTH-1:0] sb_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic             cout_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             cell_sum;
    logic             cell_cout;
    logic             last_bit;

    assign last_bit = (cnt_reg == LAST_BIT);

    // Single full-adder cell fed from the LSBs of the operand shift registers
    dataflow_fulladder u_cell (
        .first  (sa_reg[0]),
        .second (sb_reg[0]),
        .cin    (carry_reg),
        .sum    (cell_sum),
        .cout   (cell_cout)
    );

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start)    state_next = ST_RUN;
            ST_RUN:  if (last_bit) state_next = ST_DONE;
            ST_DONE:               state_next = ST_IDLE;
            default:               state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath: operand/sum shift registers, carry, counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sa_reg    <= '0;
            sb_reg    <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        sa_reg    <= a;
                        sb_reg    <= b;
                        carry_reg <= cin;
                        cnt_reg   <= '0;
                        sum_reg   <= '0;
                        cout_reg  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    sa_reg    <= sa_reg >> 1;
                    sb_reg    <= sb_reg >> 1;
                    // Sum bits enter at the MSB; after WIDTH shifts bit 0 is at sum[0]
                    sum_reg   <= {cell_sum, sum_reg[WIDTH-1:1]};
                    carry_reg <= cell_cout;
                    if (last_bit) begin
                        cout_reg <= cell_cout;
                    end else begin
                        // Held at WIDTH-1 on the final edge so it never wraps
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_reg;

    // On the final edge carry_reg is the carry into the MSB
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (state_reg == ST_IDLE && start) begin
            ovf_reg <= 1'b0;
        end else if (state_reg == ST_RUN && last_bit) begin
            ovf_reg <= carry_reg ^ cell_cout;
        end
    end

    assign ovf = ovf_reg;
`endif

    assign busy = (state_reg != ST_IDLE);
    assign done = (state_reg == ST_DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
// Self-checking bench for serial_adder (WIDTH=8): table-driven operations,
// continuous-start throughput, reset mid-operation. Expected results are
// queued at stimulus time and popped when done pulses.
// ---------------------------------------------------------------------------
module tb_serial_adder;
    import serial_adder_pkg::*;

    localparam int W = SA_WIDTH_DEF;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int errors = 0;
    int checks = 0;
    int done_count = 0;
    vec_t exp_q[$];
    vec_t vecs[8];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model for operands not listed in the table
    function automatic vec_t model(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
        vec_t r;
        logic [W:0] full;
        full       = {1'b0, va} + {1'b0, vb} + {{W{1'b0}}, vc};
        r.a        = va;
        r.b        = vb;
        r.cin      = vc;
        r.exp_sum  = full[W-1:0];
        r.exp_cout = full[W];
        r.exp_ovf  = (va[W-1] == vb[W-1]) && (full[W-1] != va[W-1]);
        return r;
    endfunction

    // Scoreboard: compare each done pulse against the oldest expected result
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            vec_t e;
            done_count++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'(0));
            end else begin
                e = exp_q.pop_front();
                $display("txn a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d (exp %02h %0d)",
                         e.a, e.b, e.cin, sum, cout, e.exp_sum, e.exp_cout);
                chk("sum", 32'(sum), 32'(e.exp_sum));
                chk("cout", 32'(cout), 32'(e.exp_cout));
`ifdef SERIAL_ADDER_OVF_EN
                chk("ovf", 32'(ovf), 32'(e.exp_ovf));
`endif
            end
        end
    end

    // One full operation with latency/busy checks; result checked by scoreboard
    task automatic do_op(input vec_t v);
        @(negedge clk);
        start = 1'b1; a = v.a; b = v.b; cin = v.cin;
        exp_q.push_back(v);
        @(posedge clk);                       // accepting edge k
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        chk("busy_after_accept", 32'(busy), 32'(1));
        chk("sum_cleared", 32'(sum), 32'(0));
        begin
            logic early = 1'b0;
            repeat (W - 1) begin
                @(negedge clk);
                if (done !== 1'b0) early = 1'b1;
            end
            chk("no_early_done", 32'(early), 32'(0));
        end
        @(negedge clk);                       // after edge k+W
        chk("done_at_k_plus_w", 32'(done), 32'(1));
        chk("busy_in_done", 32'(busy), 32'(1));
        @(negedge clk);                       // after edge k+W+1
        chk("busy_low_after", 32'(busy), 32'(0));
        chk("done_one_cycle", 32'(done), 32'(0));
        chk("sum_held", 32'(sum), 32'(v.exp_sum));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc0;
        int model_cnt;
        int accepts;

        vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[6] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};

        // Reset held 3 cycles with start asserted
        rst_n = 1'b0; start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_busy", 32'(busy), 32'(0));
            chk("rst_done", 32'(done), 32'(0));
        end
        chk("rst_sum", 32'(sum), 32'(0));
        chk("rst_cout", 32'(cout), 32'(0));
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'(0));
`endif
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_rst", 32'(busy), 32'(0));

        // Table-driven operations
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i]);
        end

        // start held high, operands changed every cycle
        dc0 = done_count;
        model_cnt = 0;
        accepts = 0;
        for (int c = 0; c < 3 * (W + 2); c++) begin
            @(negedge clk);
            start = 1'b1;
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            if (model_cnt == 0) begin
                exp_q.push_back(model(a, b, cin));
                accepts++;
                model_cnt = W + 2;
            end
            @(posedge clk);
            model_cnt--;
        end
        @(negedge clk);
        start = 1'b0;
        repeat (W + 3) @(negedge clk);
        chk("stream_done_count", 32'(done_count - dc0), 32'(accepts));
        chk("stream_queue_empty", 32'(exp_q.size()), 32'(0));

        // Reset at RUN bit 4 aborts without a done
        dc0 = done_count;
        @(negedge clk);
        start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
        @(posedge clk);                       // accept
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);            // four RUN edges done, counter = 4
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_sum", 32'(sum), 32'(0));
        chk("abort_cout", 32'(cout), 32'(0));
        repeat (W + 4) @(negedge clk);
        chk("abort_no_done", 32'(done_count - dc0), 32'(0));

        // Fresh operation after the abort
        do_op(model(8'hC3, 8'h5E, 1'b1));
        repeat (2) @(negedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_adder

// File: doc/serial_adder.md
# serial_adder

Bit-serial ripple adder that adds two WIDTH-bit operands plus carry-in one bit per clock, LSB first, through a single one-bit full-adder cell and a registered carry. It sits directly upstream of the one-bit full adder: it sequences operand bits and carry into the cell, then collects the sum bits and final carry. Throughput is traded for area in the datapath's low-rate arithmetic path.

## Interface
- Clock and reset: one clock; reset is synchronous and active-low.
- Parameters:
  - WIDTH, default 8: operand and sum width in bits. Must be 2 or more.
- Ports:
  - clk  input  1  rising-edge clock.
  - rst_n  input  1  synchronous active-low reset.
  - start  input  1  request; sampled only in IDLE.
  - a  input  WIDTH  operand A, captured on the accepting edge.
  - b  input  WIDTH  operand B, captured on the accepting edge.
  - cin  input  1  carry-in, captured on the accepting edge.
  - busy  output  1  high in RUN and DONE.
  - done  output  1  one-cycle pulse; sum and cout are valid.
  - sum  output  WIDTH  result, held until the next accepted start.
  - cout  output  1  carry out of the MSB, held with sum.
  - ovf  output  1  signed overflow; present only with SERIAL_ADDER_OVF_EN.

## Operation
- FSM states:
  - IDLE → RUN on start=1.
  - RUN → DONE when the bit counter reaches WIDTH-1.
  - DONE → IDLE unconditionally.
- Accept (IDLE, start=1):
  - Load shift registers sa←a and sb←b.
  - Load carry←cin.
  - Clear the bit counter.
  - Clear sum, cout and ovf.
- Each RUN cycle:
  - Drive the cell with first=sa[0], second=sb[0], cin=carry.
  - Shift sa and sb right by one.
  - Shift the cell's sum bit into the sum shift register at the MSB (right shift). After WIDTH shifts bit 0 lands at sum[0].
  - carry←cell cout.
  - Increment the counter.
- On the final RUN edge (counter = WIDTH-1), cout takes the cell cout.
- DONE: done=1 for exactly one cycle; busy stays high.
- Arithmetic is unsigned modulo 2^WIDTH; {cout,sum} = a+b+cin exactly.
- Counter width is $clog2(WIDTH). The counter never wraps during an operation.
- start in RUN or DONE is ignored and not queued.
- a, b and cin changing after the accepting edge have no effect.

## Timing
- Reset (rst_n=0 at an edge) forces:
  - state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0;
  - shift registers, carry and counter to 0.
- Reset mid-RUN aborts the operation. No done is produced, and the result is discarded.
- Latency: start accepted at edge k, then done=1 in the cycle after edge k+WIDTH+... precisely, state is DONE after edge k+WIDTH and done is high until edge k+WIDTH+1.
- The earliest next accept is edge k+WIDTH+2 (in IDLE). The issue interval is WIDTH+2 cycles.
- busy rises after edge k and falls after edge k+WIDTH+1.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - Port ovf exists.
  - On the final RUN edge, ovf←(carry into MSB) XOR (carry out of MSB).
  - ovf is held with sum and cleared on accept or reset.
- SERIAL_ADDER_OVF_EN undefined:
  - No ovf port and no associated logic.
  - All other behaviour is identical.

## Structure
- Shared package serial_adder_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - default width constant SA_WIDTH_DEF=8.
- One sub-module: the team's existing combinational one-bit full adder dataflow_fulladder (ports first, second, cin, sum, cout), instantiated once. There is no other hierarchy.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with start=1 → busy=0, done=0, sum=0x00, cout=0, ovf=0. No accept while in reset.
- WIDTH=8, a=0x5A, b=0x33, cin=0, start pulsed at edge k → done high after edge k+8 only, sum=0x8D, cout=0, busy back to 0 after edge k+9.
- a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1, ovf=0. Then a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0.
- a=0x7F, b=0x01, cin=0 → sum=0x80, cout=0, ovf=1 (with SERIAL_ADDER_OVF_EN). Then a=0x80, b=0x80 → sum=0x00, cout=1, ovf=1.
- start held high continuously, with operands changed every cycle during RUN → exactly one done per WIDTH+2 cycles. Each result matches the operands sampled on its accepting edge.
- rst_n=0 for one edge at RUN bit 4 → next cycle IDLE, busy=0, sum=0. done never pulses. A fresh start then completes normally.
